// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction-fetch stage of the 16-bit MIPS core.
//
// Owns the program counter, presents it to the combinational instruction ROM
// (imem_pc -> imem_instr in the same cycle) and registers the returned word
// into the IF/ID pipeline register read by decode. Supports valid/ready
// backpressure, branch/jump redirect with flush, halting, and sticky fault
// flags for out-of-range fetches and misaligned redirect targets.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   fetch_en             leave IDLE and start fetching
//   halt_req             stop fetching (enter HALT)
//   redirect/redirect_pc taken branch/jump and its target
//   id_ready             decode accepts IF/ID this cycle
//   imem_pc/imem_instr   ROM address (== pc) and returned word
//   if_instr/if_pc/if_pc_next/if_valid  IF/ID pipeline register
//   fetch_state          00 IDLE, 01 RUN, 10 HALT
//   fetch_fault          sticky: out-of-range fetch attempted
//   misalign             sticky: redirect target had nonzero low bits
//
// Optional feature macro FETCH_PERF_EN: adds saturating 32-bit counters
//   perf_fetch_cnt (captures) and perf_stall_cnt (RUN cycles stalled by decode).
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] PC_STEP    = 16'd4,
    parameter logic [15:0] IMEM_BYTES = 16'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        halt_req,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        id_ready,
    output logic [15:0] imem_pc,
    input  logic [15:0] imem_instr,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_next,
    output logic        if_valid,
    output logic [1:0]  fetch_state,
    output logic        fetch_fault,
    output logic        misalign
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] ifpc_q, ifpc_d;
    logic [15:0] ifpcn_q, ifpcn_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic        misal_q, misal_d;
    logic        load;
    logic        capture;
    logic        stall;

    // IF/ID may be overwritten when empty or when decode is taking it now.
    assign load  = !valid_q || id_ready;
    assign stall = (state_q == RUN) && valid_q && !id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ifpc_q  <= '0;
            ifpcn_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            misal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpcn_q <= ifpcn_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            misal_q <= misal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpcn_d = ifpcn_q;
        valid_d = valid_q;
        fault_d = fault_q;
        misal_d = misal_q;
        capture = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch_en) state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    // Flush wins over both halt and a decode stall.
                    pc_d    = {redirect_pc[15:2], 2'b00};
                    valid_d = 1'b0;
                    if (redirect_pc[1:0] != 2'b00) misal_d = 1'b1;
                end else if (halt_req) begin
                    state_d = HALT;
                    if (load) valid_d = 1'b0;
                end else if (pc_q >= IMEM_BYTES) begin
                    fault_d = 1'b1;
                    state_d = HALT;
                    if (load) valid_d = 1'b0;
                end else if (load) begin
                    capture = 1'b1;
                    instr_d = imem_instr;
                    ifpc_d  = pc_q;
                    ifpcn_d = pc_q + PC_STEP;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                end
            end
            HALT: begin
                // Only a redirect (restart path) or reset leaves HALT.
                if (redirect) begin
                    pc_d    = {redirect_pc[15:2], 2'b00};
                    valid_d = 1'b0;
                    state_d = RUN;
                    if (redirect_pc[1:0] != 2'b00) misal_d = 1'b1;
                end else if (valid_q && id_ready) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign imem_pc     = pc_q;
    assign if_instr    = instr_q;
    assign if_pc       = ifpc_q;
    assign if_pc_next  = ifpcn_q;
    assign if_valid    = valid_q;
    assign fetch_state = state_q;
    assign fetch_fault = fault_q;
    assign misalign    = misal_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fcnt_q, scnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            if (capture && (fcnt_q != '1)) fcnt_q <= fcnt_q + 32'd1;
            if (stall && (scnt_q != '1))   scnt_q <= scnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fcnt_q;
    assign perf_stall_cnt = scnt_q;
`else
    logic unused_perf;
    assign unused_perf = capture ^ stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
// Stimulus pushes the expected (pc, instr) of every instruction decode will
// consume into a queue; a monitor pops and compares on each if_valid&&id_ready.
// Directed point checks cover reset, stalls, redirect, faults and halting.
// ROM word at index i is 16'hA000 | i.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        halt_req;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_ready;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_next;
    logic        if_valid;
    logic [1:0]  fetch_state;
    logic        fetch_fault;
    logic        misalign;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;
    exp_t exp_q[$];

    logic [15:0] rom [16];

    always #5 clk = ~clk;

    assign imem_instr = rom[imem_pc[5:2]];

    fetch_unit #(
        .RESET_PC  (16'h0000),
        .PC_STEP   (16'd4),
        .IMEM_BYTES(16'd64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetch_en),
        .halt_req   (halt_req),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_ready   (id_ready),
        .imem_pc    (imem_pc),
        .imem_instr (imem_instr),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pc_next (if_pc_next),
        .if_valid   (if_valid),
        .fetch_state(fetch_state),
        .fetch_fault(fetch_fault),
        .misalign   (misalign)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] pc, input logic [15:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: decode consumes on if_valid && id_ready; sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && if_valid === 1'b1 && id_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL consume_unexpected: got pc %0h, expected no consumption", if_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("consume_pc_instr_next", {16'h0, if_pc, if_instr, if_pc_next},
                      {16'h0, e.pc, e.instr, e.pc + 16'd4});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int unsigned i = 0; i < 16; i++) rom[i] = 16'hA000 | 16'(i);
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        halt_req    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        id_ready    = 1'b0;

        // Reset state
        #3;
        check("reset_valid", 64'(if_valid), 64'd0);
        check("reset_pc", 64'(imem_pc), 64'h0000);
        check("reset_state", 64'(fetch_state), 64'd0);
        check("reset_flags", {62'd0, fetch_fault, misalign}, 64'd0);
        check("reset_ifid", {16'h0, if_instr, if_pc, if_pc_next}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_hold", {46'd0, fetch_state, if_valid, imem_pc}, {46'd0, 2'b00, 1'b0, 16'h0000});

        // Scenario 1: sequential fetch
        push(16'h0000, 16'hA000);
        push(16'h0004, 16'hA001);
        push(16'h0008, 16'hA002);
        push(16'h000C, 16'hA003);
        push(16'h0010, 16'hA004);
        fetch_en = 1'b1;
        id_ready = 1'b1;
        tick();
        check("run_entry", {61'd0, fetch_state, if_valid}, {61'd0, 2'b01, 1'b0});
        fetch_en = 1'b0;
        tick();
        check("first_fetch", {31'd0, if_valid, if_pc, if_instr}, {31'd0, 1'b1, 16'h0000, 16'hA000});
        tick();
        check("second_fetch", 64'(if_pc), 64'h0004);
        tick();
        check("third_fetch", 64'(if_pc), 64'h0008);

        // Scenario 2: three-cycle stall at if_pc=8
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", {15'd0, if_valid, if_pc, if_instr, imem_pc},
                  {15'd0, 1'b1, 16'h0008, 16'hA002, 16'h000C});
        end
`ifdef FETCH_PERF_EN
        check("perf_stall_3", 64'(perf_stall_cnt), 64'd3);
        check("perf_fetch_3", 64'(perf_fetch_cnt), 64'd3);
`endif
        id_ready = 1'b1;
        tick();
        check("after_stall", 64'(if_pc), 64'h000C);
        tick();
        check("seq_16", 64'(if_pc), 64'h0010);
        tick();
        check("seq_20", {32'd0, if_pc, if_instr}, {32'd0, 16'h0014, 16'hA005});

        // Scenario 3: redirect during a stall flushes if_pc=20
        id_ready = 1'b0;
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0004;
        push(16'h0004, 16'hA001);
        tick();
        check("redirect_flush", {47'd0, if_valid, imem_pc}, {47'd0, 1'b0, 16'h0004});
        redirect = 1'b0;
        id_ready = 1'b1;
        tick();
        check("redirect_target", {47'd0, if_valid, if_pc}, {47'd0, 1'b1, 16'h0004});

        // Scenario 4: misaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 16'h0007;
        for (int unsigned p = 4; p <= 60; p += 4) push(16'(p), 16'hA000 | 16'(p >> 2));
        tick();
        check("misalign_pc", {46'd0, misalign, if_valid, imem_pc}, {46'd0, 1'b1, 1'b0, 16'h0004});
        redirect = 1'b0;

        // Scenario 5: run off the end of the ROM
        for (int i = 0; i < 40 && fetch_fault !== 1'b1; i++) tick();
        check("fault_set", 64'(fetch_fault), 64'd1);
        check("fault_halt", {45'd0, fetch_state, if_valid, imem_pc}, {45'd0, 2'b10, 1'b0, 16'h0040});
        check("misalign_sticky", 64'(misalign), 64'd1);
        halt_req = 1'b1;
        fetch_en = 1'b1;
        tick();
        check("halt_ignores", {46'd0, fetch_state, imem_pc}, {46'd0, 2'b10, 16'h0040});
        halt_req    = 1'b0;
        fetch_en    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        push(16'h0000, 16'hA000);
        tick();
        check("restart", {45'd0, fetch_state, if_valid, imem_pc}, {45'd0, 2'b01, 1'b0, 16'h0000});
        redirect = 1'b0;
        tick();
        check("restart_fetch", {47'd0, if_valid, if_pc}, {47'd0, 1'b1, 16'h0000});

        // halt_req in RUN with decode ready
        halt_req = 1'b1;
        tick();
        check("halt_enter", {45'd0, fetch_state, if_valid, imem_pc}, {45'd0, 2'b10, 1'b0, 16'h0004});
        check("fault_sticky", 64'(fetch_fault), 64'd1);
        halt_req = 1'b0;

        // Scenario 6: asynchronous reset mid-stream
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect = 1'b0;
        tick();
        check("pre_reset_valid", {47'd0, if_valid, if_pc}, {47'd0, 1'b1, 16'h0010});
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {45'd0, fetch_state, if_valid, imem_pc}, {45'd0, 2'b00, 1'b0, 16'h0000});
        check("async_reset_flags", {62'd0, fetch_fault, misalign}, 64'd0);
`ifdef FETCH_PERF_EN
        check("perf_reset", {perf_fetch_cnt, perf_stall_cnt}, 64'd0);
`endif
        #2;
        rst_n = 1'b1;
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
